// File: rtl/commit_trace_buf.sv
// Commit trace buffer: records retired-instruction entries into a show-ahead FIFO from arm
// until a PC-match, full or cycle-limit halt; entries drain through rd_pop in any state.
`timescale 1ns/1ps
module commit_trace_buf #(
    parameter  int unsigned DW      = 32,
    parameter  int unsigned DEPTH   = 16,
    parameter  int unsigned CYC_W   = 16,
    parameter  int unsigned WRAP    = 0,
    localparam int unsigned ENTRY_W = 2 * DW + 38,
    localparam int unsigned CW      = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               arm,
    input  logic               clear,
    input  logic               cmt_valid,
    input  logic [DW-1:0]      cmt_pc,
    input  logic [31:0]        cmt_instr,
    input  logic [4:0]         cmt_rd,
    input  logic               cmt_we,
    input  logic [DW-1:0]      cmt_wdata,
    input  logic               halt_en,
    input  logic [DW-1:0]      halt_pc,
    input  logic [CYC_W-1:0]   max_cycles,
    input  logic               rd_pop,
    output logic               rd_valid,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [CW-1:0]      count,
    output logic [1:0]         state,
    output logic [1:0]         halt_cause,
    output logic               overflow,
    output logic [CYC_W-1:0]   cycle_cnt
);

    localparam int unsigned   AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam bit            WRAP_EN  = (WRAP != 0);

    localparam logic [1:0] CAUSE_NONE   = 2'd0;
    localparam logic [1:0] CAUSE_PC     = 2'd1;
    localparam logic [1:0] CAUSE_FULL   = 2'd2;
    localparam logic [1:0] CAUSE_CYCLES = 2'd3;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StHalted  = 2'd2
    } state_e;

    state_e             r_state;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [1:0]         r_halt_cause;
    logic               r_overflow;
    logic [CYC_W-1:0]   r_cycle_cnt;
    logic [ENTRY_W-1:0] r_mem [DEPTH];

    logic               w_capture;
    logic               w_pop;
    logic               w_full;
    logic               w_push_req;
    logic               w_pc_hit;
    logic               w_blocked;
    logic               w_push;
    logic               w_overwrite;
    logic               w_cyc_hit;
    logic [CYC_W-1:0]   w_cyc_next;
    logic [1:0]         w_cause;
    logic [CW-1:0]      w_count_next;
    logic [ENTRY_W-1:0] w_entry;

    assign w_entry = {cmt_pc, cmt_instr, cmt_rd, cmt_we, cmt_wdata};

    always_comb begin
        w_capture  = (r_state == StCapture);
        w_pop      = rd_pop && (r_count != '0);
        w_full     = (r_count == FULL_CNT);
        w_push_req = w_capture && cmt_valid && !clear;
        w_pc_hit   = w_push_req && halt_en && (cmt_pc == halt_pc);
        // A pop in the same cycle frees the slot, so only an unpopped full buffer blocks.
        w_blocked   = w_push_req && w_full && !w_pop && !WRAP_EN;
        w_push      = w_push_req && !w_blocked;
        w_overwrite = w_push && w_full && !w_pop;

        w_cyc_next = (&r_cycle_cnt) ? r_cycle_cnt : r_cycle_cnt + CYC_W'(1);
        w_cyc_hit  = w_capture && (max_cycles != '0) && (w_cyc_next == max_cycles);

        w_cause = CAUSE_NONE;
        if (w_pc_hit) begin
            w_cause = CAUSE_PC;
        end else if (w_blocked) begin
            w_cause = CAUSE_FULL;
        end else if (w_cyc_hit) begin
            w_cause = CAUSE_CYCLES;
        end

        w_count_next = r_count;
        if (w_push && !w_pop && !w_overwrite) begin
            w_count_next = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= StIdle;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_halt_cause <= CAUSE_NONE;
            r_overflow   <= 1'b0;
            r_cycle_cnt  <= '0;
        end else if (clear) begin
            r_state      <= StIdle;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_halt_cause <= CAUSE_NONE;
            r_overflow   <= 1'b0;
            r_cycle_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            // Overwriting the oldest entry retires it, so the read side advances too.
            if (w_pop || w_overwrite) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
            if (w_overwrite) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                StIdle: begin
                    if (arm) begin
                        r_state <= StCapture;
                    end
                end
                StCapture: begin
                    r_cycle_cnt <= w_cyc_next;
                    if (w_cause != CAUSE_NONE) begin
                        r_state      <= StHalted;
                        r_halt_cause <= w_cause;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    assign rd_valid   = (r_count != '0);
    assign rd_data    = r_mem[r_rd_ptr];
    assign count      = r_count;
    assign state      = r_state;
    assign halt_cause = r_halt_cause;
    assign overflow   = r_overflow;
    assign cycle_cnt  = r_cycle_cnt;

endmodule

// File: tb/tb_commit_trace_buf.sv
// Bench for commit_trace_buf: a stop-when-full and a wrapping instance share stimulus;
// directed scenarios plus random traffic against a list-based model of each.
`timescale 1ns/1ps
module tb_commit_trace_buf;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CYC_W = 16;
    localparam int EW    = 2 * DW + 38;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rstn;
    logic             arm;
    logic             clear;
    logic             cmt_valid;
    logic [DW-1:0]    cmt_pc;
    logic [31:0]      cmt_instr;
    logic [4:0]       cmt_rd;
    logic             cmt_we;
    logic [DW-1:0]    cmt_wdata;
    logic             halt_en;
    logic [DW-1:0]    halt_pc;
    logic [CYC_W-1:0] max_cycles;
    logic             rd_pop;

    logic             rv   [2];
    logic [EW-1:0]    rdat [2];
    logic [CW-1:0]    cnt  [2];
    logic [1:0]       st   [2];
    logic [1:0]       hc   [2];
    logic             ovf  [2];
    logic [CYC_W-1:0] cyc  [2];

    int checks = 0;
    int errors = 0;

    // Model: each buffer is an ordered list, oldest at index 0.
    int            m_state [2];
    int            m_n     [2];
    logic [EW-1:0] m_buf   [2][DEPTH];
    bit            m_ovf   [2];
    int            m_cause [2];
    int            m_cyc   [2];

    always #5 clk = ~clk;

    commit_trace_buf #(.DW(DW), .DEPTH(DEPTH), .CYC_W(CYC_W), .WRAP(0)) u_dut_stop (
        .clk(clk), .rstn(rstn), .arm(arm), .clear(clear), .cmt_valid(cmt_valid),
        .cmt_pc(cmt_pc), .cmt_instr(cmt_instr), .cmt_rd(cmt_rd), .cmt_we(cmt_we),
        .cmt_wdata(cmt_wdata), .halt_en(halt_en), .halt_pc(halt_pc), .max_cycles(max_cycles),
        .rd_pop(rd_pop), .rd_valid(rv[0]), .rd_data(rdat[0]), .count(cnt[0]), .state(st[0]),
        .halt_cause(hc[0]), .overflow(ovf[0]), .cycle_cnt(cyc[0])
    );

    commit_trace_buf #(.DW(DW), .DEPTH(DEPTH), .CYC_W(CYC_W), .WRAP(1)) u_dut_wrap (
        .clk(clk), .rstn(rstn), .arm(arm), .clear(clear), .cmt_valid(cmt_valid),
        .cmt_pc(cmt_pc), .cmt_instr(cmt_instr), .cmt_rd(cmt_rd), .cmt_we(cmt_we),
        .cmt_wdata(cmt_wdata), .halt_en(halt_en), .halt_pc(halt_pc), .max_cycles(max_cycles),
        .rd_pop(rd_pop), .rd_valid(rv[1]), .rd_data(rdat[1]), .count(cnt[1]), .state(st[1]),
        .halt_cause(hc[1]), .overflow(ovf[1]), .cycle_cnt(cyc[1])
    );

    function automatic logic [EW-1:0] mk_entry(input logic [31:0] pc);
        return {pc, pc ^ 32'hA5A5_0000, pc[6:2], 1'b1, ~pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [31:0] pc);
        cmt_valid = 1'b1;
        cmt_pc    = pc;
        cmt_instr = pc ^ 32'hA5A5_0000;
        cmt_rd    = pc[6:2];
        cmt_we    = 1'b1;
        cmt_wdata = ~pc;
        tick();
        cmt_valid = 1'b0;
    endtask

    task automatic pop();
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
    endtask

    task automatic start_trace();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        arm   = 1'b1;
        tick();
        arm   = 1'b0;
    endtask

    task automatic m_pop(input int k);
        for (int i = 0; i < DEPTH - 1; i++) m_buf[k][i] = m_buf[k][i+1];
        m_n[k]--;
    endtask

    task automatic m_push(input int k);
        m_buf[k][m_n[k]] = {cmt_pc, cmt_instr, cmt_rd, cmt_we, cmt_wdata};
        m_n[k]++;
    endtask

    task automatic model_step(input int k, input bit wrap);
        bit popping;
        bit pc_hit;
        bit blocked;
        bit cyc_hit;
        int cause;
        if (clear) begin
            m_state[k] = 0;
            m_n[k]     = 0;
            m_ovf[k]   = 1'b0;
            m_cause[k] = 0;
            m_cyc[k]   = 0;
            return;
        end
        popping = rd_pop && (m_n[k] > 0);
        if (m_state[k] == 0) begin
            if (arm) m_state[k] = 1;
        end else if (m_state[k] == 1) begin
            pc_hit  = 1'b0;
            blocked = 1'b0;
            if (m_cyc[k] < 65535) m_cyc[k]++;
            cyc_hit = (max_cycles != '0) && (m_cyc[k] == int'(max_cycles));
            if (cmt_valid) begin
                pc_hit = halt_en && (cmt_pc == halt_pc);
                if (popping) begin
                    m_pop(k);
                    popping = 1'b0;
                end
                if (m_n[k] < DEPTH) begin
                    m_push(k);
                end else if (wrap) begin
                    m_pop(k);
                    m_push(k);
                    m_ovf[k] = 1'b1;
                end else begin
                    blocked = 1'b1;
                end
            end
            cause = pc_hit ? 1 : blocked ? 2 : cyc_hit ? 3 : 0;
            if (cause != 0) begin
                m_state[k] = 2;
                m_cause[k] = cause;
            end
        end
        if (popping) m_pop(k);
    endtask

    task automatic test_reset();
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (st[k] !== 2'd0 || cnt[k] !== 3'd0 || rv[k] !== 1'b0 || hc[k] !== 2'd0 ||
                ovf[k] !== 1'b0 || cyc[k] !== 16'd0) begin
                errors++;
                $display("FAIL reset[%0d]: got st=%0d cnt=%0d rv=%0b hc=%0d ovf=%0b cyc=%0d exp all 0",
                         k, st[k], cnt[k], rv[k], hc[k], ovf[k], cyc[k]);
            end
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_full_halt();
        start_trace();
        for (int i = 0; i < 5; i++) commit(32'h200 + 32'(4 * i));
        checks++;
        if (cnt[0] !== 3'd4 || st[0] !== 2'd2 || hc[0] !== 2'd2) begin
            errors++;
            $display("FAIL full_halt: got cnt=%0d st=%0d hc=%0d exp cnt=4 st=2 hc=2",
                     cnt[0], st[0], hc[0]);
        end
        checks++;
        if (rdat[0] !== mk_entry(32'h200)) begin
            errors++;
            $display("FAIL full_oldest: got %h exp %h", rdat[0], mk_entry(32'h200));
        end
    endtask

    task automatic test_wrap();
        start_trace();
        for (int i = 0; i < 6; i++) commit(32'h200 + 32'(4 * i));
        checks++;
        if (cnt[1] !== 3'd4 || ovf[1] !== 1'b1 || st[1] !== 2'd1 || hc[1] !== 2'd0) begin
            errors++;
            $display("FAIL wrap_fill: got cnt=%0d ovf=%0b st=%0d hc=%0d exp cnt=4 ovf=1 st=1 hc=0",
                     cnt[1], ovf[1], st[1], hc[1]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rv[1] !== 1'b1 || rdat[1] !== mk_entry(32'h200 + 32'(4 * (i + 2)))) begin
                errors++;
                $display("FAIL wrap_pop%0d: got rv=%0b data=%h exp rv=1 data=%h", i, rv[1],
                         rdat[1], mk_entry(32'h200 + 32'(4 * (i + 2))));
            end
            pop();
        end
        checks++;
        if (rv[1] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_empty: got rv=%0b exp 0", rv[1]);
        end
    endtask

    task automatic test_pc_halt();
        halt_en = 1'b1;
        halt_pc = 32'h198;
        start_trace();
        commit(32'h190);
        commit(32'h194);
        commit(32'h198);
        commit(32'h19C);
        halt_en = 1'b0;
        checks++;
        if (cnt[0] !== 3'd3 || hc[0] !== 2'd1 || st[0] !== 2'd2) begin
            errors++;
            $display("FAIL pc_halt: got cnt=%0d hc=%0d st=%0d exp cnt=3 hc=1 st=2",
                     cnt[0], hc[0], st[0]);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rdat[0] !== mk_entry(32'h190 + 32'(4 * i))) begin
                errors++;
                $display("FAIL pc_entry%0d: got %h exp %h", i, rdat[0],
                         mk_entry(32'h190 + 32'(4 * i)));
            end
            pop();
        end
        checks++;
        if (rv[0] !== 1'b0) begin
            errors++;
            $display("FAIL pc_absent: got rv=%0b exp 0", rv[0]);
        end
    endtask

    task automatic test_cycle_limit();
        int n;
        max_cycles = 16'd10;
        start_trace();
        n = 0;
        while (st[0] != 2'd2 && n < 50) begin
            tick();
            n++;
        end
        max_cycles = '0;
        checks++;
        if (n != 10 || cyc[0] !== 16'd10 || hc[0] !== 2'd3) begin
            errors++;
            $display("FAIL cycle_limit: got cycles=%0d cyc=%0d hc=%0d exp 10 10 3",
                     n, cyc[0], hc[0]);
        end
    endtask

    task automatic test_push_pop_full();
        start_trace();
        for (int i = 0; i < 4; i++) commit(32'h300 + 32'(4 * i));
        rd_pop = 1'b1;
        commit(32'h310);
        rd_pop = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (cnt[k] !== 3'd4 || ovf[k] !== 1'b0 || st[k] !== 2'd1 || hc[k] !== 2'd0) begin
                errors++;
                $display("FAIL pushpop[%0d]: got cnt=%0d ovf=%0b st=%0d hc=%0d exp 4 0 1 0",
                         k, cnt[k], ovf[k], st[k], hc[k]);
            end
        end
        checks++;
        if (rdat[0] !== mk_entry(32'h304)) begin
            errors++;
            $display("FAIL pushpop_head: got %h exp %h", rdat[0], mk_entry(32'h304));
        end
        halt_en = 1'b1;
        halt_pc = 32'h314;
        commit(32'h314);
        halt_en = 1'b0;
        checks++;
        if (hc[0] !== 2'd1 || st[0] !== 2'd2 || cnt[0] !== 3'd4 || hc[1] !== 2'd1) begin
            errors++;
            $display("FAIL pc_on_full: got hc0=%0d st0=%0d cnt0=%0d hc1=%0d exp 1 2 4 1",
                     hc[0], st[0], cnt[0], hc[1]);
        end
    endtask

    task automatic test_async_reset();
        start_trace();
        for (int i = 0; i < 3; i++) commit(32'h400 + 32'(4 * i));
        checks++;
        if (cnt[0] !== 3'd3 || st[0] !== 2'd1) begin
            errors++;
            $display("FAIL pre_reset: got cnt=%0d st=%0d exp 3 1", cnt[0], st[0]);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (rv[0] !== 1'b0 || st[0] !== 2'd0 || cnt[0] !== 3'd0 || cyc[0] !== 16'd0 ||
            rv[1] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got rv=%0b st=%0d cnt=%0d cyc=%0d exp 0 0 0 0",
                     rv[0], st[0], cnt[0], cyc[0]);
        end
        tick();
        rstn = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (st[0] !== 2'd0) begin
            errors++;
            $display("FAIL no_rearm: got st=%0d exp 0", st[0]);
        end
        arm = 1'b1;
        tick();
        arm = 1'b0;
        checks++;
        if (st[0] !== 2'd1) begin
            errors++;
            $display("FAIL rearm: got st=%0d exp 1", st[0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            clear = (c == 0) || ($urandom_range(0, 39) == 0) ||
                    (m_state[0] == 2 && m_state[1] == 2 && $urandom_range(0, 7) == 0);
            if (clear) begin
                max_cycles = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(1, 40)) : '0;
                halt_en    = ($urandom_range(0, 2) == 0);
                halt_pc    = 32'h100 + 32'(4 * $urandom_range(0, 15));
            end
            arm       = ($urandom_range(0, 2) == 0);
            cmt_valid = ($urandom_range(0, 1) == 1);
            cmt_pc    = 32'h100 + 32'(4 * $urandom_range(0, 15));
            cmt_instr = $urandom;
            cmt_rd    = 5'($urandom);
            cmt_we    = 1'($urandom);
            cmt_wdata = $urandom;
            rd_pop    = ($urandom_range(0, 2) == 0);
            model_step(0, 1'b0);
            model_step(1, 1'b1);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (st[k] !== 2'(m_state[k]) || hc[k] !== 2'(m_cause[k])) begin
                    errors++;
                    $display("FAIL rnd_state[%0d] c=%0d: got st=%0d hc=%0d exp st=%0d hc=%0d",
                             k, c, st[k], hc[k], m_state[k], m_cause[k]);
                end
                checks++;
                if (cnt[k] !== 3'(m_n[k]) || rv[k] !== (m_n[k] > 0) || ovf[k] !== m_ovf[k]) begin
                    errors++;
                    $display("FAIL rnd_occ[%0d] c=%0d: got cnt=%0d rv=%0b ovf=%0b exp %0d %0b %0b",
                             k, c, cnt[k], rv[k], ovf[k], m_n[k], m_n[k] > 0, m_ovf[k]);
                end
                checks++;
                if (cyc[k] !== 16'(m_cyc[k])) begin
                    errors++;
                    $display("FAIL rnd_cyc[%0d] c=%0d: got %0d exp %0d", k, c, cyc[k], m_cyc[k]);
                end
                if (m_n[k] > 0) begin
                    checks++;
                    if (rdat[k] !== m_buf[k][0]) begin
                        errors++;
                        $display("FAIL rnd_data[%0d] c=%0d: got %h exp %h", k, c, rdat[k],
                                 m_buf[k][0]);
                    end
                end
            end
        end
        clear     = 1'b0;
        arm       = 1'b0;
        cmt_valid = 1'b0;
        rd_pop    = 1'b0;
    endtask

    initial begin
        rstn       = 1'b0;
        arm        = 1'b0;
        clear      = 1'b0;
        cmt_valid  = 1'b0;
        cmt_pc     = '0;
        cmt_instr  = '0;
        cmt_rd     = '0;
        cmt_we     = 1'b0;
        cmt_wdata  = '0;
        halt_en    = 1'b0;
        halt_pc    = '0;
        max_cycles = '0;
        rd_pop     = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0;
            m_n[k]     = 0;
            m_ovf[k]   = 1'b0;
            m_cause[k] = 0;
            m_cyc[k]   = 0;
        end
        test_reset();
        test_full_halt();
        test_wrap();
        test_pc_halt();
        test_cycle_limit();
        test_push_pop_full();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1);
    end

endmodule
